// File: rtl/pulse_seq_if.sv
// pulse_seq_if: command, configuration and status bundle for pulse_sequencer
//   start/stop/mode/modulus/burst_len : commands and config from the front end
//   busy/done/res/pulse_cnt/cfg_err   : registered status from the sequencer
interface pulse_seq_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
   logic start, stop, mode, busy, done, res, cfg_err;
   logic [WIDTH-1:0] modulus;
   logic [CNT_W-1:0] burst_len, pulse_cnt;
   modport master(output start, stop, mode, modulus, burst_len, input busy, done, res, pulse_cnt, cfg_err);
   modport slave(input start, stop, mode, modulus, burst_len, output busy, done, res, pulse_cnt, cfg_err);
endinterface

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: start/stop controller for a modulo-M pulse generator with optional finite bursts
//   clk, rst : single clock, synchronous active-high reset
//   bus      : pulse_seq_if.slave (start, stop, mode, modulus, burst_len in; busy, done, res, pulse_cnt, cfg_err out)
//   PRESCALE_EN : when defined, the counter advances once every PRESCALE clocks instead of every clock
module pulse_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
`ifdef PRESCALE_EN
   , parameter int PRESCALE = 4
`endif
) (
   input logic clk,
   input logic rst,
   pulse_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] m, cter;
   logic [CNT_W-1:0] k;
   logic burst, tick, term, last, bad, accept;
   assign bad = bus.modulus == '0 || (bus.mode && bus.burst_len == '0);
   assign accept = state == IDLE && bus.start && !bus.stop && !bad;
   assign term = cter == m - 1'b1;
   assign last = burst && bus.pulse_cnt + 1'b1 == k;
`ifdef PRESCALE_EN
   localparam int PW = PRESCALE > 2 ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
   logic [PW-1:0] pre;
   assign tick = pre == PLAST;
   // cleared on accept so the first tick lands PRESCALE clocks after the accept edge
   always_ff @(posedge clk)
      if (rst || accept) pre <= '0;
      else pre <= tick ? '0 : pre + 1'b1;
`else
   assign tick = 1'b1;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cter <= '0;
         m <= '0;
         k <= '0;
         burst <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.res <= 1'b0;
         bus.cfg_err <= 1'b0;
         bus.pulse_cnt <= '0;
      end else begin
         bus.done <= 1'b0;
         bus.res <= 1'b0;
         bus.cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               bus.busy <= accept;
               bus.cfg_err <= bus.start && !bus.stop && bad;
               if (accept) begin
                  m <= bus.modulus;
                  k <= bus.burst_len;
                  burst <= bus.mode;
                  cter <= '0;
                  bus.pulse_cnt <= '0;
                  state <= RUN;
               end
            end
            RUN:
               if (bus.stop) begin
                  cter <= '0;
                  bus.busy <= 1'b0;
                  state <= IDLE;
               end else if (tick) begin
                  cter <= term ? '0 : cter + 1'b1;
                  bus.res <= term;
                  if (term) bus.pulse_cnt <= bus.pulse_cnt + 1'b1;
                  if (term && last) state <= DONE;
               end
            DONE: begin
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: table-driven directed check of pulse_sequencer
module tb_pulse_sequencer;
   typedef struct {
      logic [3:0] in;
      logic [7:0] m;
      logic [7:0] k;
      int n;
      logic [3:0] out;
      logic [7:0] cnt;
   } vec_t;
`ifdef PRESCALE_EN
   localparam int P = 4;
`else
   localparam int P = 1;
`endif
   logic clk = 1'b0;
   logic rst;
   int total = 0;
   int bad = 0;
   vec_t vecs[$];
   pulse_seq_if #(.WIDTH(8), .CNT_W(8)) bus();
   pulse_sequencer #(.WIDTH(8), .CNT_W(8)) dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic add(input logic [3:0] in, input logic [7:0] m, input logic [7:0] k, input int n, input logic [3:0] out, input logic [7:0] cnt);
      vec_t v;
      v.in = in;
      v.m = m;
      v.k = k;
      v.n = n;
      v.out = out;
      v.cnt = cnt;
      vecs.push_back(v);
   endtask
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask
   // in = {rst,start,stop,mode}; out = {busy,done,res,cfg_err}; inputs held for n edges, then outputs checked
   task automatic run(input vec_t v, input int idx);
      {rst, bus.start, bus.stop, bus.mode} = v.in;
      bus.modulus = v.m;
      bus.burst_len = v.k;
      repeat (v.n) @(posedge clk);
      #1;
      check($sformatf("row%0d {busy,done,res,err,cnt}", idx), {20'd0, bus.busy, bus.done, bus.res, bus.cfg_err, bus.pulse_cnt}, {20'd0, v.out, v.cnt});
   endtask
   initial begin
      int cyc;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.mode = 1'b0;
      bus.modulus = '0;
      bus.burst_len = '0;
      add(4'b1000, 8'd0, 8'd0, 2, 4'b0000, 8'd0);
`ifdef PRESCALE_EN
      add(4'b0101, 8'd2, 8'd2, 1, 4'b1000, 8'd0);
      add(4'b0000, 8'd2, 8'd2, 7, 4'b1000, 8'd0);
      add(4'b0000, 8'd2, 8'd2, 1, 4'b1010, 8'd1);
      add(4'b0000, 8'd2, 8'd2, 7, 4'b1000, 8'd1);
      add(4'b0000, 8'd2, 8'd2, 1, 4'b1010, 8'd2);
      add(4'b0000, 8'd2, 8'd2, 1, 4'b0100, 8'd2);
      add(4'b0000, 8'd2, 8'd2, 1, 4'b0000, 8'd2);
`else
      add(4'b0100, 8'd8, 8'd0, 1, 4'b1000, 8'd0);
      add(4'b0000, 8'd8, 8'd0, 7, 4'b1000, 8'd0);
      add(4'b0000, 8'd8, 8'd0, 1, 4'b1010, 8'd1);
      add(4'b0000, 8'd8, 8'd0, 1, 4'b1000, 8'd1);
      add(4'b0000, 8'd8, 8'd0, 7, 4'b1010, 8'd2);
      add(4'b0000, 8'd8, 8'd0, 8, 4'b1010, 8'd3);
      add(4'b0010, 8'd8, 8'd0, 1, 4'b0000, 8'd3);
      add(4'b0000, 8'd8, 8'd0, 1, 4'b0000, 8'd3);
      add(4'b0101, 8'd3, 8'd4, 1, 4'b1000, 8'd0);
      add(4'b0000, 8'd9, 8'd1, 2, 4'b1000, 8'd0);
      add(4'b0000, 8'd9, 8'd1, 1, 4'b1010, 8'd1);
      add(4'b0000, 8'd9, 8'd1, 2, 4'b1000, 8'd1);
      add(4'b0000, 8'd9, 8'd1, 1, 4'b1010, 8'd2);
      add(4'b0000, 8'd9, 8'd1, 3, 4'b1010, 8'd3);
      add(4'b0000, 8'd9, 8'd1, 3, 4'b1010, 8'd4);
      add(4'b0000, 8'd9, 8'd1, 1, 4'b0100, 8'd4);
      add(4'b0000, 8'd9, 8'd1, 1, 4'b0000, 8'd4);
      add(4'b0100, 8'd0, 8'd0, 1, 4'b0001, 8'd4);
      add(4'b0000, 8'd0, 8'd0, 1, 4'b0000, 8'd4);
      add(4'b0101, 8'd5, 8'd0, 1, 4'b0001, 8'd4);
      add(4'b0000, 8'd5, 8'd0, 1, 4'b0000, 8'd4);
      add(4'b0100, 8'd8, 8'd0, 1, 4'b1000, 8'd0);
      add(4'b0000, 8'd8, 8'd0, 7, 4'b1000, 8'd0);
      add(4'b0000, 8'd8, 8'd0, 1, 4'b1010, 8'd1);
      add(4'b0000, 8'd8, 8'd0, 7, 4'b1000, 8'd1);
      add(4'b0010, 8'd8, 8'd0, 1, 4'b0000, 8'd1);
      add(4'b0000, 8'd8, 8'd0, 1, 4'b0000, 8'd1);
      add(4'b0110, 8'd8, 8'd0, 1, 4'b0000, 8'd1);
      add(4'b0110, 8'd0, 8'd0, 1, 4'b0000, 8'd1);
      add(4'b0000, 8'd8, 8'd0, 1, 4'b0000, 8'd1);
      add(4'b0101, 8'd4, 8'd10, 1, 4'b1000, 8'd0);
      add(4'b0000, 8'd4, 8'd10, 16, 4'b1010, 8'd4);
      add(4'b1000, 8'd4, 8'd10, 1, 4'b0000, 8'd0);
      add(4'b0101, 8'd2, 8'd1, 1, 4'b1000, 8'd0);
      add(4'b0000, 8'd2, 8'd1, 1, 4'b1000, 8'd0);
      add(4'b0000, 8'd2, 8'd1, 1, 4'b1010, 8'd1);
      add(4'b0000, 8'd2, 8'd1, 1, 4'b0100, 8'd1);
      add(4'b0000, 8'd2, 8'd1, 1, 4'b0000, 8'd1);
      add(4'b0101, 8'd1, 8'd2, 1, 4'b1000, 8'd0);
      add(4'b0101, 8'd1, 8'd2, 1, 4'b1010, 8'd1);
      add(4'b0101, 8'd1, 8'd2, 1, 4'b1010, 8'd2);
      add(4'b0101, 8'd1, 8'd2, 1, 4'b0100, 8'd2);
      add(4'b0101, 8'd1, 8'd2, 1, 4'b1000, 8'd0);
      add(4'b0101, 8'd1, 8'd2, 1, 4'b1010, 8'd1);
      add(4'b0001, 8'd1, 8'd2, 1, 4'b1010, 8'd2);
      add(4'b0001, 8'd1, 8'd2, 1, 4'b0100, 8'd2);
      add(4'b0000, 8'd1, 8'd2, 1, 4'b0000, 8'd2);
      add(4'b0100, 8'd1, 8'd0, 1, 4'b1000, 8'd0);
      add(4'b0000, 8'd1, 8'd0, 255, 4'b1010, 8'd255);
      add(4'b0000, 8'd1, 8'd0, 1, 4'b1010, 8'd0);
      add(4'b0010, 8'd1, 8'd0, 1, 4'b0000, 8'd0);
      add(4'b0000, 8'd1, 8'd0, 1, 4'b0000, 8'd0);
`endif
      foreach (vecs[i]) run(vecs[i], i);
      {rst, bus.stop} = 2'b00;
      bus.start = 1'b1;
      bus.mode = 1'b1;
      bus.modulus = 8'd5;
      bus.burst_len = 8'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("done_latency", cyc, 15 * P + 1);
      check("done_cnt", {24'd0, bus.pulse_cnt}, 32'd3);
      @(posedge clk);
      #1;
      check("after_done_idle", {29'd0, bus.busy, bus.done, bus.res}, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Controller for the modulo-N pulse generator datapath. Accepts start/stop commands and a latched configuration (modulus, run mode, burst length), then runs the modulo counter. Emits a one-cycle pulse on each terminal count and signals completion of finite bursts. Sits between the lab's switch/button front end and downstream counters/displays that consume the periodic pulse.

Parameters:
WIDTH, 8, width of modulus and internal modulo counter
CNT_W, 8, width of burst length and emitted-pulse counter
PRESCALE, 4, tick divide ratio when PRESCALE_EN is defined (must be >= 2)

Ports:
clk  in  1  single system clock; all logic on posedge clk
rst  in  1  synchronous, active-high reset
start  in  1  level-sampled command; accepted only in IDLE
stop  in  1  level-sampled abort command
mode  in  1  0 = continuous, 1 = burst; latched on start accept
modulus  in  WIDTH  terminal count M; latched on start accept
burst_len  in  CNT_W  pulses per burst K; latched on start accept
busy  out  1  high in RUN
done  out  1  one-cycle pulse at burst completion
res  out  1  one-cycle pulse at each terminal count
pulse_cnt  out  CNT_W  pulses emitted since last start accept
cfg_err  out  1  one-cycle pulse when start is rejected for bad config

Behaviour:
- Reset (rst=1 at posedge): state IDLE; cter=0; busy, done, res, cfg_err = 0; pulse_cnt = 0. Reset asserted mid-RUN aborts at that edge with no done.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: if stop=1, start is ignored (stop wins). Else if start=1:
  - If M==0, or mode=1 with K==0: cfg_err=1 for one cycle, stay IDLE, no registers latched.
  - Otherwise: latch M, K, mode; cter<=0; pulse_cnt<=0; go RUN.
- RUN: busy=1. On each tick (see Optional Feature; tick=1 every cycle by default):
  - If cter==M-1: cter<=0, res<=1, pulse_cnt<=pulse_cnt+1.
  - Else: cter<=cter+1, res<=0.
  - res=0 on cycles without a tick.
- Latency: start sampled at edge E0 -> first res high in the cycle after edge E_M (E0 + M ticks). M=1 gives res on every tick, i.e. continuously high.
- Burst mode: the tick that makes pulse_cnt==K emits that final res and moves to DONE.
- DONE: lasts one cycle with done=1, busy=0, res=0. Next edge returns to IDLE. pulse_cnt holds K.
- Continuous mode: runs until stop. pulse_cnt wraps modulo 2^CNT_W.
- stop=1 in RUN: next edge goes to IDLE, cter<=0, res<=0, no done. pulse_cnt holds its value.
- stop coinciding with a terminal tick: stop wins and that res is suppressed.
- start in RUN or DONE: ignored. Config inputs may change freely after latch without effect.
- start held high continuously: re-accepted on the first IDLE cycle, i.e. back-to-back bursts with one DONE cycle between them.

Optional Feature:
PRESCALE_EN
- Defined: internal prescaler produces tick as a one-cycle synchronous enable every PRESCALE clk cycles. No derived clock; single clock domain. Prescaler is cleared on start accept, so the first tick occurs PRESCALE cycles after E0. Latency becomes M*PRESCALE cycles.
- Undefined: tick is tied to 1 and prescaler logic is absent.

Test Plan:
1. rst, then start, mode=0, M=8 -> res high for 1 cycle at cycles 8, 16, 24 after the accept edge. busy=1 throughout. pulse_cnt = 1, 2, 3.
2. start, mode=1, M=3, K=4 -> res at cycles 3, 6, 9, 12. done=1 at cycle 13. busy=0 from cycle 13. pulse_cnt=4. State IDLE at cycle 14.
3. start with M=0 -> cfg_err pulse, busy stays 0. start with mode=1, M=5, K=0 -> cfg_err pulse.
4. Continuous run with M=8, stop asserted on the cycle of the 2nd terminal tick -> no 2nd res, no done, busy=0 next cycle, pulse_cnt=1. start+stop together in IDLE -> remain IDLE.
5. Burst M=4, K=10, rst at cycle 17 -> all outputs 0 next cycle. Subsequent start behaves as from a fresh reset.
6. PRESCALE_EN, PRESCALE=4, M=2, mode=1, K=2 -> res at cycles 8 and 16, done at 17. Continuous M=1, CNT_W=8 -> pulse_cnt wraps 255 -> 0.
